sort4_seq_ctrl: RTL and testbench

SORT4_SEQ_CTRL -- requirements
Module: sort4_seq_ctrl

---
 rtl/sort_pkg.sv | 31 +++
 rtl/max_comparator.sv | 16 +
 rtl/sort4_seq_ctrl.sv | 118 +++++++++++
 tb/tb_sort4_seq_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the sequential 4-element sorter: sizes, FSM states and
// the compare-exchange schedule run by the single shared comparator.
package sort_pkg;

  localparam int DATA_W  = 13;
  localparam int N_ELEM  = 4;
  localparam int N_STEPS = 5;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  // Operand indices (a, b) and the destinations of the larger (hi) and smaller (lo) result.
  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] hi;
    logic [1:0] lo;
  } step_ops_t;

  localparam step_ops_t STEP_TABLE [N_STEPS] = '{
    '{a: 2'd0, b: 2'd1, hi: 2'd0, lo: 2'd1},
    '{a: 2'd2, b: 2'd3, hi: 2'd2, lo: 2'd3},
    '{a: 2'd0, b: 2'd2, hi: 2'd0, lo: 2'd2},
    '{a: 2'd1, b: 2'd3, hi: 2'd1, lo: 2'd3},
    '{a: 2'd2, b: 2'd1, hi: 2'd1, lo: 2'd2}
  };

endpackage

// File: rtl/max_comparator.sv
// Signed two's-complement max/min compare; ties route operand a to max_val.
module max_comparator #(
  parameter int W = 13
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] max_val,
  output logic signed [W-1:0] min_val,
  output logic                compare_result
);

  assign compare_result = (a >= b);
  assign max_val        = compare_result ? a : b;
  assign min_val        = compare_result ? b : a;

endmodule

// File: rtl/sort4_seq_ctrl.sv
// Sequential descending sort of a 4-element signed vector using one shared
// comparator stepped over a five-step compare-exchange network.
module sort4_seq_ctrl #(
  parameter int DATA_W = sort_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_mat4 [0:3],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_mat4 [0:3],
  output logic                     busy,
  output logic [CNT_W-1:0]         sort_cnt
);

  import sort_pkg::state_t;
  import sort_pkg::IDLE;
  import sort_pkg::CMP;
  import sort_pkg::DONE;
  import sort_pkg::step_ops_t;
  import sort_pkg::STEP_TABLE;
  import sort_pkg::N_ELEM;
  import sort_pkg::N_STEPS;

  localparam logic [2:0] LAST_STEP = 3'(N_STEPS - 1);

  state_t                   state;
  logic [2:0]               step;
  logic signed [DATA_W-1:0] r     [0:N_ELEM-1];
  logic signed [DATA_W-1:0] r_cmp [0:N_ELEM-1];
  logic signed [DATA_W-1:0] op_a, op_b, max_val, min_val;
  logic                     cmp_unused;
  step_ops_t                ops;

  assign ops  = STEP_TABLE[step];
  assign op_a = r[ops.a];
  assign op_b = r[ops.b];

  max_comparator #(.W(DATA_W)) u_cmp (
    .a              (op_a),
    .b              (op_b),
    .max_val        (max_val),
    .min_val        (min_val),
    .compare_result (cmp_unused)
  );

  // NOTE: every element gets its default first so no path through the mux can infer a latch.
  always_comb begin
    for (int i = 0; i < N_ELEM; i++) begin
      r_cmp[i] = r[i];
      if (2'(i) == ops.hi)      r_cmp[i] = max_val;
      else if (2'(i) == ops.lo) r_cmp[i] = min_val;
    end
  end

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_mat4 = r;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the small register file is reset too, so out_mat4 never shows stale data after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      r         <= '{default: '0};
      sort_cnt  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (clear) begin
      // Abort keeps the register contents; only control returns to IDLE.
      state     <= IDLE;
      step      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            r     <= in_mat4;
            step  <= '0;
            state <= CMP;
            busy  <= 1'b1;
          end
        end
        CMP: begin
          r <= r_cmp;
          if (step == LAST_STEP) begin
            state     <= DONE;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end else begin
            step <= step + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            sort_cnt  <= sort_cnt + CNT_W'(1);
            out_valid <= 1'b0;
            if (in_valid) begin
              r     <= in_mat4;
              step  <= '0;
              state <= CMP;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort4_seq_ctrl.sv
// Directed bench for sort4_seq_ctrl: table of sort vectors plus hand-written
// backpressure, back-to-back, abort and reset sequences.
module tb_sort4_seq_ctrl;

  localparam int DATA_W = 13;
  localparam int CNT_W  = 3;

  typedef int vec4_t [4];
  typedef struct {
    string name;
    vec4_t vin;
    vec4_t vout;
  } tv_t;

  logic clk = 1'b0;
  logic rst, clear, in_valid, out_ready;
  logic in_ready, out_valid, busy;
  logic signed [DATA_W-1:0] in_mat4  [0:3];
  logic signed [DATA_W-1:0] out_mat4 [0:3];
  logic [CNT_W-1:0] sort_cnt;

  int checks   = 0;
  int failures = 0;
  logic [CNT_W-1:0] exp_cnt;
  tv_t tv [7];

  always #5 clk = ~clk;

  sort4_seq_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mat4   (in_mat4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mat4  (out_mat4),
    .busy      (busy),
    .sort_cnt  (sort_cnt)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_vec(input vec4_t v);
    for (int i = 0; i < 4; i++) in_mat4[i] = DATA_W'(v[i]);
  endtask

  task automatic check_out(input string name, input vec4_t e);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s out_mat4[%0d]", name, i), longint'(out_mat4[i]), longint'(e[i]));
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Bounded wait for out_valid; edges is the number of rising edges consumed.
  task automatic wait_valid(input string name, output int edges);
    edges = 0;
    do begin
      cycle();
      edges++;
    end while (!out_valid && edges < 20);
    if (!out_valid) check({name, " out_valid timeout"}, 0, 1);
  endtask

  task automatic run_vec(input string name, input vec4_t v, input vec4_t e);
    int edges;
    check({name, " in_ready idle"}, longint'(in_ready), 1);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    drive_vec(v);
    cycle();
    in_valid = 1'b0;
    drive_vec('{1234, -1234, 999, -999});
    check({name, " busy"}, longint'(busy), 1);
    wait_valid(name, edges);
    check({name, " latency"}, edges, 5);
    check_out(name, e);
    check({name, " busy done"}, longint'(busy), 0);
    check({name, " cnt before"}, longint'(sort_cnt), longint'(exp_cnt));
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    exp_cnt++;
    check({name, " cnt after"}, longint'(sort_cnt), longint'(exp_cnt));
    check({name, " out_valid cleared"}, longint'(out_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e1, e2, seen;

    tv[0] = '{"basic",   '{3, -7, 12, 0},           '{12, 3, 0, -7}};
    tv[1] = '{"ties",    '{-4096, 4095, 4095, -4096}, '{4095, 4095, -4096, -4096}};
    tv[2] = '{"ascend",  '{1, 2, 3, 4},             '{4, 3, 2, 1}};
    tv[3] = '{"sorted",  '{-1, -2, -3, -4},         '{-1, -2, -3, -4}};
    tv[4] = '{"equal",   '{5, 5, 5, 5},             '{5, 5, 5, 5}};
    tv[5] = '{"mixed",   '{-100, 200, -300, 400},   '{400, 200, -100, -300}};
    tv[6] = '{"extreme", '{0, -4096, 4095, 1},      '{4095, 1, 0, -4096}};

    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive_vec('{0, 0, 0, 0});
    exp_cnt   = '0;
    #1;
    check("reset out_valid", longint'(out_valid), 0);
    check("reset busy", longint'(busy), 0);
    check("reset in_ready", longint'(in_ready), 1);
    check("reset sort_cnt", longint'(sort_cnt), 0);
    check_out("reset", '{0, 0, 0, 0});
    #20;
    @(negedge clk);
    rst = 1'b0;
    cycle();

    for (int t = 0; t < 7; t++) run_vec(tv[t].name, tv[t].vin, tv[t].vout);

    // Backpressure: hold DONE for 10 cycles while a new vector waits; also the 8th delivery wraps sort_cnt.
    in_valid = 1'b1;
    drive_vec('{-5, 7, 0, 2});
    cycle();
    in_valid = 1'b0;
    wait_valid("bp", e1);
    check("bp latency", e1, 5);
    in_valid = 1'b1;
    drive_vec('{100, 100, 100, 100});
    for (int c = 0; c < 10; c++) begin
      cycle();
      check("bp out_valid hold", longint'(out_valid), 1);
      check("bp in_ready low", longint'(in_ready), 0);
      check("bp sort_cnt hold", longint'(sort_cnt), longint'(exp_cnt));
      check_out("bp hold", '{7, 2, 0, -5});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    exp_cnt++;
    check("bp cnt wrap", longint'(sort_cnt), longint'(exp_cnt));
    check("bp cnt wrapped to zero", longint'(sort_cnt), 0);

    // Back-to-back: second vector accepted on the delivery edge of the first.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    drive_vec('{1, 2, 3, 4});
    cycle();
    drive_vec('{8, 5, 6, 7});
    wait_valid("b2b first", e1);
    check("b2b first latency", e1, 5);
    check_out("b2b first", '{4, 3, 2, 1});
    check("b2b in_ready", longint'(in_ready), 1);
    cycle();
    in_valid = 1'b0;
    exp_cnt++;
    check("b2b cnt first", longint'(sort_cnt), longint'(exp_cnt));
    check("b2b busy no idle", longint'(busy), 1);
    wait_valid("b2b second", e2);
    check("b2b spacing", e2 + 1, 6);
    check_out("b2b second", '{8, 7, 6, 5});
    cycle();
    out_ready = 1'b0;
    exp_cnt++;
    check("b2b cnt second", longint'(sort_cnt), longint'(exp_cnt));
    check("b2b out_valid cleared", longint'(out_valid), 0);

    // Abort at step 2.
    in_valid = 1'b1;
    drive_vec('{9, 1, 2, 3});
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    check("abort busy", longint'(busy), 0);
    check("abort out_valid", longint'(out_valid), 0);
    check("abort in_ready", longint'(in_ready), 1);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (out_valid) seen++;
    end
    check("abort no out_valid", seen, 0);
    check("abort sort_cnt", longint'(sort_cnt), longint'(exp_cnt));
    run_vec("after abort", '{0, 0, 0, 1}, '{1, 0, 0, 0});

    // Reset during step 3.
    in_valid = 1'b1;
    drive_vec('{4, 3, 2, 1});
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    cycle();
    check("pre-rst busy", longint'(busy), 1);
    rst = 1'b1;
    #1;
    check("midrst out_valid", longint'(out_valid), 0);
    check("midrst busy", longint'(busy), 0);
    check("midrst in_ready", longint'(in_ready), 1);
    check("midrst sort_cnt", longint'(sort_cnt), 0);
    check("midrst out_mat4[0]", longint'(out_mat4[0]), 0);
    exp_cnt = '0;
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (out_valid) seen++;
    end
    check("postrst no out_valid", seen, 0);
    run_vec("after reset", '{2, -2, 7, -7}, '{7, 2, -2, -7});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
